// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types for the instruction/data memory-port arbiter.
// Revision : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef struct packed {
        src_e src;
        logic drop;
    } txn_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } lock_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_resp_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : resp_id_fifo
// Purpose  : Source-ID FIFO of outstanding memory transactions with flush-drop.
// Revision : 1.0
// ============================================================================
module resp_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  txn_id_t                      push_entry,
    input  logic                         pop,
    input  logic                         mark_drop,
    output logic                         full,
    output logic                         empty,
    output txn_id_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    txn_id_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;
    txn_id_t            w_wr_entry;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full       = (r_count == CNT_W'(DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign head       = r_mem[r_rd_ptr];
    assign w_push_ok  = push & ~full;
    assign w_pop_ok   = pop & ~empty;

    // A flush that coincides with the push must also tag the incoming entry.
    always_comb begin
        w_wr_entry      = push_entry;
        w_wr_entry.drop = push_entry.drop | (mark_drop & (push_entry.src == SRC_INSTR));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '{src: SRC_INSTR, drop: 1'b0};
            end
        end else begin
            if (mark_drop) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_mem[i].src == SRC_INSTR) begin
                        r_mem[i].drop <= 1'b1;
                    end
                end
            end
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_wr_entry;
                r_wr_ptr        <= inc_ptr(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= inc_ptr(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch and the LSU.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        instr_flush_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

    lock_e               r_lock;
    lock_e               w_lock_nxt;
    logic [STARVE_W-1:0] r_starve;
    logic                w_sel_instr;
    logic                w_granted;
    logic                w_full;
    logic                w_empty;
    logic                w_resp_live;
    txn_id_t             w_head;
    txn_id_t             w_push_entry;
    logic [CNT_W-1:0]    w_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock <= IDLE;
        end else begin
            r_lock <= w_lock_nxt;
        end
    end

    always_comb begin
        w_lock_nxt   = r_lock;
        w_sel_instr  = 1'b0;
        mem_req_o    = (instr_req_i | data_req_i) & ~w_full;
        w_granted    = mem_req_o & mem_gnt_i;

        case (r_lock)
            LOCK_I:  w_sel_instr = 1'b1;
            LOCK_D:  w_sel_instr = 1'b0;
            default: w_sel_instr = instr_req_i &
                                   ((r_starve == STARVE_W'(STARVE_LIMIT)) | ~data_req_i);
        endcase

        // Hold the choice across gnt wait so the requester is never switched.
        case (r_lock)
            IDLE:    if (mem_req_o & ~mem_gnt_i) w_lock_nxt = w_sel_instr ? LOCK_I : LOCK_D;
            LOCK_I:  if (w_granted | instr_flush_i) w_lock_nxt = IDLE;
            LOCK_D:  if (w_granted) w_lock_nxt = IDLE;
            default: w_lock_nxt = IDLE;
        endcase

        instr_gnt_o = w_granted & w_sel_instr;
        data_gnt_o  = w_granted & ~w_sel_instr;

        mem_we_o    = mem_req_o & ~w_sel_instr & data_we_i;
        mem_be_o    = mem_req_o ? (w_sel_instr ? 4'hF : data_be_i) : 4'h0;
        mem_addr_o  = mem_req_o ? (w_sel_instr ? instr_addr_i : data_addr_i) : 32'h0;
        mem_wdata_o = (mem_req_o & ~w_sel_instr) ? data_wdata_i : 32'h0;

        w_push_entry = '{src: (w_sel_instr ? SRC_INSTR : SRC_DATA), drop: 1'b0};

        w_resp_live    = mem_rvalid_i & ~w_empty & ~w_head.drop;
        instr_rvalid_o = w_resp_live & (w_head.src == SRC_INSTR);
        data_rvalid_o  = w_resp_live & (w_head.src == SRC_DATA);
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
        instr_err_o    = instr_rvalid_o & mem_err_i;
        data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;
        data_err_o     = data_rvalid_o & mem_err_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (instr_gnt_o || !instr_req_i) begin
            r_starve <= '0;
        end else if (r_starve != STARVE_W'(STARVE_LIMIT)) begin
            r_starve <= r_starve + STARVE_W'(1);
        end
    end

    resp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_granted),
        .push_entry (w_push_entry),
        .pop        (mem_rvalid_i),
        .mark_drop  (instr_flush_i),
        .full       (w_full),
        .empty      (w_empty),
        .head       (w_head),
        .count      (w_count)
    );

endmodule
`default_nettype wire
